// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit_serializer slice.
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } ser_state_t;

  localparam int unsigned SER_DEFAULT_WIDTH = 8;

  // Width of the bit counter that indexes 0..width-1.
  function automatic int unsigned ser_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_skid_buffer.sv
// One-entry holding register for a word accepted while the shifter is busy.
module ser_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Capture on push, release on pop; the two never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      assert (!(push && pop));
      if (push) begin
        data <= load_data;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first
// bit stream out with frame_start / word_done markers.
// Optional feature: define SER_PARITY_EN to append an even-parity bit per word.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int unsigned    CW       = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold_data, load_word;
  logic             hold_full, push, pop, accept, final_bit, load;
  logic             bit_out_n, bit_valid_n, frame_start_n, word_done_n;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  assign in_ready  = !hold_full && !reset;
  assign accept    = in_valid && in_ready;
  assign load_word = hold_full ? hold_data : in_data;

  ser_skid_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .load_data (in_data),
    .data      (hold_data),
    .full      (hold_full)
  );

  // Next-state, shifter/holding control and next registered outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    push    = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
`ifdef SER_PARITY_EN
    par_n     = par;
    final_bit = (state == S_PARITY);
`else
    final_bit = (state == S_SHIFT) && (cnt == CNT_LAST);
`endif

    if (state == S_IDLE || final_bit) begin
      // Buffered word has priority; when the buffer is full in_ready is low.
      cnt_n = '0;
      if (hold_full || accept) begin
        load    = 1'b1;
        pop     = hold_full;
        state_n = S_SHIFT;
        shreg_n = load_word;
`ifdef SER_PARITY_EN
        par_n   = ^load_word;
`endif
      end else begin
        state_n = S_IDLE;
      end
    end else if (state == S_SHIFT) begin
      push    = accept;
      shreg_n = {shreg[WIDTH-2:0], 1'b0};
      cnt_n   = cnt + CW'(1);
`ifdef SER_PARITY_EN
      if (cnt == CNT_LAST) begin
        state_n = S_PARITY;
        cnt_n   = '0;
      end
`endif
    end else begin
      state_n = S_IDLE;
    end

    // Outputs describe the bit presented in the next cycle.
    bit_valid_n   = (state_n != S_IDLE);
    frame_start_n = load;
    bit_out_n     = (state_n == S_SHIFT) ? shreg_n[WIDTH-1] : 1'b0;
`ifdef SER_PARITY_EN
    if (state_n == S_PARITY) bit_out_n = par_n;
    word_done_n   = (state_n == S_PARITY);
`else
    word_done_n   = (state_n == S_SHIFT) && (cnt_n == CNT_LAST);
`endif
  end

  // State, shifter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      word_done   <= 1'b0;
`ifdef SER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      bit_out     <= bit_out_n;
      bit_valid   <= bit_valid_n;
      frame_start <= frame_start_n;
      word_done   <= word_done_n;
`ifdef SER_PARITY_EN
      par         <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8), honours SER_PARITY_EN.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int WP = 8 + (PAR ? 1 : 0);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, bit_out, bit_valid, frame_start, word_done;

  bit_serializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .word_done   (word_done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of the bits still owed to the output.
  typedef struct packed {
    logic v;
    logic b;
    logic fs;
    logic wd;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  logic rdy_seen, last_acc;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       b;
    logic       bv;
    logic       fs;
    logic       wd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--)
      q.push_back('{v: 1'b1, b: w[i], fs: (i == 7), wd: (!PAR && i == 0)});
    if (PAR) q.push_back('{v: 1'b1, b: ^w, fs: 1'b0, wd: 1'b1});
  endfunction

  // A word is waiting (not yet started) when any queued bit opens a frame.
  function automatic logic waiting();
    foreach (q[i]) if (q[i].fs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    ev_t  e;
    logic exp_rdy;
    @(negedge clk);
    reset = r; in_valid = v; in_data = d;
    #1;
    exp_rdy  = !r && !waiting();
    rdy_seen = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    last_acc = v && exp_rdy;
    @(posedge clk);
    #1;
    e = '0;
    if (r) q.delete();
    else begin
      if (last_acc) push_word(d);
      if (q.size() > 0) e = q.pop_front();
    end
    chk("bit_valid", bit_valid, e.v);
    chk("bit_out", bit_out, e.b);
    chk("frame_start", frame_start, e.fs);
    chk("word_done", word_done, e.wd);
  endtask

  task automatic addv(input logic r, v, input logic [7:0] d,
                      input logic rdy, b, bv, fs, wd);
    tbl.push_back('{rst: r, vld: v, data: d, rdy: rdy, b: b, bv: bv, fs: fs, wd: wd});
  endtask

  initial begin
    int         idx, run, max_run, cnt;
    logic [7:0] words[3];
    logic [7:0] cap;

    // Directed table: single word with fixed expected waveform.
    addv(1, 0, 8'h00, 0, 0, 0, 0, 0);
`ifdef SER_PARITY_EN
    addv(0, 1, 8'h07, 1, 0, 1, 1, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 0, 0);
    addv(0, 1, 8'h03, 1, 0, 1, 1, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 0, 0);
`else
    addv(0, 1, 8'hA5, 1, 1, 1, 1, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 0, 0);
    addv(0, 0, 8'h00, 1, 1, 1, 0, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 0, 0);
`endif
    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].vld, tbl[i].data);
      chk("tbl_ready", rdy_seen, tbl[i].rdy);
      chk("tbl_bit", bit_out, tbl[i].b);
      chk("tbl_valid", bit_valid, tbl[i].bv);
      chk("tbl_fs", frame_start, tbl[i].fs);
      chk("tbl_wd", word_done, tbl[i].wd);
    end

    // Back-to-back words with in_valid held: one unbroken run of valid bits.
    words[0] = 8'hAA; words[1] = 8'h0F; words[2] = 8'hF0;
    idx = 0; run = 0; max_run = 0;
    for (int c = 0; c < 3 * WP + 8; c++) begin
      tick(1'b0, idx < 3, (idx < 3) ? words[idx] : 8'h00);
      if (last_acc) idx++;
      run = bit_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("b2b_accepted", 8'(idx), 8'd3);
    chk("b2b_run", 8'(max_run), 8'(3 * WP));

    // Detector pattern: MSB appears in the first cycle after the accept.
    tick(1'b0, 1'b1, 8'h5A);
    chk("det_accept", last_acc, 1'b1);
    cap = '0;
    cap[7] = bit_out;
    chk("det_first_fs", frame_start, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      tick(1'b0, 1'b0, 8'h00);
      cap[i] = bit_out;
    end
    chk("det_stream", cap, 8'h5A);
    for (int i = 0; i < WP - 7; i++) tick(1'b0, 1'b0, 8'h00);

    // Reset during bit 4 of 8'hC3 with a second word buffered.
    tick(1'b0, 1'b1, 8'hC3);
    tick(1'b0, 1'b1, 8'h3C);
    chk("rst_hold_accept", last_acc, 1'b1);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    chk("rst_mid_valid", bit_valid, 1'b0);
    tick(1'b0, 1'b0, 8'h00);
    chk("rst_release_ready", rdy_seen, 1'b1);
    cnt = 0;
    for (int i = 0; i < 2 * WP; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (bit_valid) cnt++;
    end
    chk("rst_no_resume", 8'(cnt), 8'd0);

    // in_valid during reset is ignored.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'hFF);
    cnt = 0;
    for (int i = 0; i < 2 * WP; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (bit_valid) cnt++;
    end
    chk("rst_valid_ignored", 8'(cnt), 8'd0);

    // Randomized traffic with occasional resets against the queue model.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3;
      tick($urandom_range(0, 249) == 0,
           (dens == 0) ? ($urandom_range(0, 3) != 0) :
           (dens == 1) ? ($urandom_range(0, 7) == 0) : 1'b1,
           8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, as a qualified bit stream. The stream drives the serial `in` input of the downstream sequence detector. A one-entry holding buffer lets back-to-back words stream with no idle cycles between them.

## Interface
- WIDTH, 8, word width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- in_data  input  WIDTH  word to serialize
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- bit_out  output  1  serial bit; 0 when bit_valid=0
- bit_valid  output  1  bit_out carries a real bit
- frame_start  output  1  high with the first (MSB) bit of each word
- word_done  output  1  high with the last bit of each word (the parity bit when enabled)

## Operation
- Handshake: a word is accepted on a rising edge where in_valid && in_ready.
- in_ready = !hold_full && !reset.
- FSM states: S_IDLE, S_SHIFT, S_PARITY.
  - S_IDLE → S_SHIFT on accept; the word loads directly into the shift register (bypass).
  - S_SHIFT: outputs shreg[WIDTH-1], shifts left, increments bit_cnt (0..WIDTH-1).
  - At bit_cnt == WIDTH-1: go to S_PARITY if parity is enabled.
  - Otherwise, reload from the holding buffer if it is full, or from an accept in the same cycle (stay in S_SHIFT, bit_cnt=0). If neither, go to S_IDLE.
  - S_PARITY: outputs the parity bit, then follows the same reload/idle rule.
- Holding buffer: a word accepted while the shifter is mid-word goes into hold_reg and sets hold_full.
- An accept in the final bit cycle with the buffer empty bypasses straight into the shifter.
- Hold full and final bit cycle: hold_reg moves to the shifter and hold_full clears. in_ready was 0 that cycle, so no simultaneous accept is possible.
- bit_out is forced to 0 whenever bit_valid=0, so the downstream detector sees 0 on idle cycles.

## Timing
- Reset values: bit_out=0, bit_valid=0, frame_start=0, word_done=0, hold_full=0, state=S_IDLE, bit_cnt=0. in_ready=0 while reset is high and 1 the cycle after.
- Latency: accept at edge k (shifter idle) → MSB on bit_out with bit_valid=1 and frame_start=1 in the cycle after edge k.
- Word period: WIDTH cycles, or WIDTH+1 with parity. Back-to-back words give continuous bit_valid=1.
- Outputs are registered; in_ready is combinational from hold_full and reset only.
- Reset mid-word: the partial word and the buffered word are both discarded. bit_valid=0 from the cycle after the reset edge, and no truncated word_done is produced.
- in_valid asserted while reset is high is ignored.

## Configuration
- SER_PARITY_EN defined: after the LSB, one extra bit of even parity (XOR of all WIDTH data bits) is emitted. word_done accompanies the parity bit.
- SER_PARITY_EN undefined: S_PARITY is not built, the word period is exactly WIDTH, and word_done accompanies the LSB.

## Structure
- Package ser_pkg:
  - state enum ser_state_t {S_IDLE, S_SHIFT, S_PARITY}
  - localparam SER_DEFAULT_WIDTH = 8
  - function for the bit_cnt width, $clog2(WIDTH)
- One sub-module, ser_skid_buffer: the one-entry holding register.
  - Signals: push, pop, data, full.
  - Push and pop in the same cycle is illegal by construction; assert on it in simulation.

## Test plan
- Single word: 8'hA5 accepted with the shifter idle → bit_out 1,0,1,0,0,1,0,1 over 8 consecutive cycles. frame_start on cycle 1, word_done on cycle 8, then bit_valid=0 and bit_out=0.
- Back-to-back: 8'hAA, 8'h0F, 8'hF0 with in_valid held high → 24 consecutive bit_valid cycles with no gaps. in_ready drops while hold is full and rises in the cycle after each reload.
- Detector pattern: word 8'h5A → serial stream 0101 1010 feeds the detector. Check alignment: bit 1 of the stream is the MSB, in the first cycle after the accept.
- Parity (SER_PARITY_EN): 8'h07 → 9 bits 0,0,0,0,0,1,1,1,1 with word_done on the 9th bit. 8'h03 → 9th bit 0.
- Reset mid-word: reset asserted during bit 4 of 8'hC3 with a second word buffered → bit_valid=0 the next cycle, in_ready=1 after reset deasserts, and neither word resumes.
- in_valid=1 during reset → no word accepted, no bit_valid after reset release.
